// File: rtl/turn_signal_sequencer.sv
// -----------------------------------------------------------------------------
// turn_signal_sequencer
//
// Dashboard turn-signal controller. The formatted 2-bit button code is
// registered, debounced and edge-detected into press events. The events drive
// an OFF / LEFT / RIGHT / HAZARD mode machine. A blink timer then produces the
// lamp phase and counts lamp on-phases for the dash display.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles before a code is accepted (>= 2)
//   BLINK_HALF       clk cycles per lamp half-period (>= 2)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   btn_code     button code: 0 none, 1 left, 2 right, 3 hazard
//   mode         current mode-machine state: 0 OFF, 1 LEFT, 2 RIGHT, 3 HAZARD
//   lamp_left    left indicator lamp drive
//   lamp_right   right indicator lamp drive
//   flash_count  lamp on-phases since the last mode change, saturating at 255
// -----------------------------------------------------------------------------
module turn_signal_sequencer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int BLINK_HALF      = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] btn_code,
   output logic [1:0] mode,
   output logic       lamp_left,
   output logic       lamp_right,
   output logic [7:0] flash_count
);

   localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF - 1);

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_LEFT   = 2'd1,
      ST_RIGHT  = 2'd2,
      ST_HAZARD = 2'd3
   } mode_t;

   logic [1:0]         btn_q;
   logic [1:0]         cand;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         stable;
   logic [1:0]         stable_d;
   logic               press;

   mode_t              state;
   mode_t              state_next;

   logic [BLINK_W-1:0] blink_cnt;
   logic               phase;

   // Input register doubles as the synchroniser stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q <= 2'd0;
      end else begin
         btn_q <= btn_code;
      end
   end

   // Debounce: cand tracks the latest sampled code; once it has been seen
   // unchanged for DEBOUNCE_CYCLES consecutive compares it is copied to stable.
   // cnt parks at its maximum so a long hold keeps re-loading the same value.
   always_ff @(posedge clk) begin
      if (rst) begin
         cand     <= 2'd0;
         cnt      <= '0;
         stable   <= 2'd0;
         stable_d <= 2'd0;
      end else begin
         stable_d <= stable;
         if (btn_q != cand) begin
            cand <= btn_q;
            cnt  <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= cand;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Press event: any change of the debounced code to a nonzero value.
   // Releases to 0 are deliberately not events.
   assign press = (stable != stable_d) && (stable != 2'd0);

   // Mode machine: state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_OFF;
      end else begin
         state <= state_next;
      end
   end

   // Mode machine: next state. Left/right toggle their own mode and steal
   // from the opposite side; hazard overrides both and only hazard exits it.
   always_comb begin
      state_next = state;
      if (press) begin
         case (stable)
            2'd1: begin
               case (state)
                  ST_OFF:    state_next = ST_LEFT;
                  ST_LEFT:   state_next = ST_OFF;
                  ST_RIGHT:  state_next = ST_LEFT;
                  default:   state_next = ST_HAZARD;
               endcase
            end
            2'd2: begin
               case (state)
                  ST_OFF:    state_next = ST_RIGHT;
                  ST_RIGHT:  state_next = ST_OFF;
                  ST_LEFT:   state_next = ST_RIGHT;
                  default:   state_next = ST_HAZARD;
               endcase
            end
            2'd3: begin
               if (state == ST_HAZARD) begin
                  state_next = ST_OFF;
               end else begin
                  state_next = ST_HAZARD;
               end
            end
            default: state_next = state;
         endcase
      end
   end

   // Blink timer. A mode change restarts the timer lit, so the first flash
   // is a full half-period; this takes priority over a wrap on the same edge.
   // flash_count counts only the off->on toggles.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt   <= '0;
         phase       <= 1'b0;
         flash_count <= 8'd0;
      end else if (state_next == ST_OFF) begin
         blink_cnt   <= '0;
         phase       <= 1'b0;
         flash_count <= 8'd0;
      end else if (state_next != state) begin
         blink_cnt   <= '0;
         phase       <= 1'b1;
         flash_count <= 8'd1;
      end else if (blink_cnt == BLINK_MAX) begin
         blink_cnt <= '0;
         phase     <= ~phase;
         if (!phase && (flash_count != 8'd255)) begin
            flash_count <= flash_count + 8'd1;
         end
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Mode output is the state register itself; lamps decode it with phase.
   assign mode       = state;
   assign lamp_left  = phase && ((state == ST_LEFT)  || (state == ST_HAZARD));
   assign lamp_right = phase && ((state == ST_RIGHT) || (state == ST_HAZARD));

endmodule

// File: doc/turn_signal_sequencer.md
Name: turn_signal_sequencer

Overview:
- Controller for the dashboard turn-signal lamps, driven by the 2-bit button code.
- Debounces the code, then detects press events.
- Sequences an OFF / LEFT / RIGHT / HAZARD mode FSM.
- Times the lamp blink and counts flashes for the dash display.
- Sits downstream of the button formatting stage; lamp and count outputs feed the display/LED drivers.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a button code must be stable before it is accepted (min 2).
- BLINK_HALF, 25000000: clk cycles per lamp half-period (on time = off time; min 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_code  input  2  formatted button code: 0 none, 1 left, 2 right, 3 hazard.
- mode  output  2  current FSM state: 0 OFF, 1 LEFT, 2 RIGHT, 3 HAZARD.
- lamp_left  output  1  left indicator lamp drive.
- lamp_right  output  1  right indicator lamp drive.
- flash_count  output  8  lamp on-phases since the last mode change; saturates at 255.

Behaviour:
- Reset: when rst is sampled high, all registers clear on that edge:
  - btn_q, cand, cnt, stable and stable_d = 0.
  - mode = OFF; phase = 0; blink counter = 0.
  - lamp_left = lamp_right = 0; flash_count = 0.
  - Reset mid-blink or mid-debounce drops straight to OFF with lamps dark; no pending event survives.
- Input register: btn_q <= btn_code every cycle (also the sync stage).
- Debounce, per edge:
  - if btn_q != cand: cand <= btn_q, cnt <= 0;
  - else if cnt == DEBOUNCE_CYCLES-1: stable <= cand, cnt holds;
  - else cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches stable.
- Edge detect: stable_d <= stable every cycle. A press event fires on the cycle where stable != stable_d and stable != 0. Release (stable goes to 0) is not an event. A direct change from one nonzero code to another is an event carrying the new code.
- Latency: btn_code held from edge 0 → mode updated at edge DEBOUNCE_CYCLES+2.
- FSM transitions, on event only. No event or code 0 → state holds.
  - Code 1: OFF→LEFT, LEFT→OFF, RIGHT→LEFT, HAZARD→HAZARD (ignored).
  - Code 2: OFF→RIGHT, RIGHT→OFF, LEFT→RIGHT, HAZARD→HAZARD (ignored).
  - Code 3: OFF, LEFT, RIGHT→HAZARD; HAZARD→OFF.
- Blink timer:
  - On any edge where mode changes to non-OFF: counter <= 0, phase <= 1, flash_count <= 1.
  - Otherwise, in a non-OFF state: counter increments. At counter == BLINK_HALF-1 it wraps to 0 and phase toggles.
  - Each 0→1 phase toggle increments flash_count, saturating at 255 with no wrap.
  - When mode becomes or stays OFF: counter = 0, phase = 0, flash_count = 0.
- Lamps (combinational from registered state and phase, no added latency):
  - LEFT: lamp_left = phase, lamp_right = 0.
  - RIGHT: lamp_right = phase, lamp_left = 0.
  - HAZARD: both = phase.
  - OFF: both 0.
- Simultaneous events: an event and a blink wrap on the same edge → the event wins; the timer restarts with phase = 1.
- Lamp is lit the cycle mode changes, so the first flash is always a full half-period.
- Widths: the blink counter is sized to hold BLINK_HALF-1; cnt is sized to hold DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_HALF=8):
- Reset, then btn_code=1 held 10 cycles → mode=1 at edge 6; lamp_left=1 for 8 cycles, then 0 for 8 cycles, repeating; lamp_right=0 throughout; flash_count reads 1, 2, 3 at the start of each on-phase.
- btn_code=2 pulsed for 3 cycles only, then 0 → stable never changes; mode stays 0; lamps stay 0.
- In LEFT, release to 0 then press 1 (held ≥6 cycles) → mode=0, both lamps 0, flash_count=0. Then press 3 → mode=3, both lamps blink in phase. Then press 1 → mode stays 3.
- In LEFT, btn_code changes directly 1→2 and is held → mode=2 at edge 6 after the change; lamp_right=1 immediately; counter restarted; flash_count=1.
- In HAZARD for 260 on-phases → flash_count=255 and holds; lamps keep blinking.
- Assert rst for 1 cycle while in RIGHT with lamp lit and a debounce in progress → next edge: mode=0, lamps 0, flash_count=0. The in-flight code must be re-held a full 4 cycles to register.
